// File: rtl/toeplitz_block_ctrl.sv
// Toeplitz hash block sequencer.
// Sequence: start -> feed KEY_WORDS key words to the core -> wait for core_done
// -> drain the captured result to the output FIFO, least-significant word first.
// Optional build macro TOEP_AUTO_RESTART_EN: while start is held high, DONE
// chains straight into the next block's FEED without passing through IDLE.
module toeplitz_block_ctrl #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned RESULT_W  = 3072,
  parameter int unsigned KEY_WORDS = 128,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic [WORD_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                core_load,
  output logic [WORD_W-1:0]   core_data,
  output logic                core_last,
  input  logic                core_done,
  input  logic [RESULT_W-1:0] core_result,
  input  logic                fifo_full,
  output logic                fifo_wr,
  output logic [WORD_W-1:0]   fifo_data,
  output logic [15:0]         blk_cnt
);

  localparam int unsigned NWORDS = RESULT_W / WORD_W;
  localparam int unsigned KC_W   = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
  localparam int unsigned IX_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned WT_W   = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FEED  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic [KC_W-1:0]     r_key_cnt;
  logic [WT_W-1:0]     r_wait_cnt;
  logic [IX_W-1:0]     r_idx;
  logic [RESULT_W-1:0] r_shadow;
  logic [WORD_W-1:0]   r_core_data;
  logic                r_core_load;
  logic                r_core_last;
  logic                r_fifo_wr;
  logic [WORD_W-1:0]   r_fifo_data;
  logic                r_done;
  logic                r_err;
  logic [15:0]         r_blk_cnt;

  logic w_hs;
  logic w_key_last;
  logic w_timeout;
  logic w_last_word;

  assign in_ready    = (r_state == S_FEED);
  assign busy        = (r_state != S_IDLE);
  assign w_hs        = in_valid & in_ready;
  assign w_key_last  = (r_key_cnt == KC_W'(KEY_WORDS - 1));
  assign w_timeout   = (r_wait_cnt == WT_W'(TIMEOUT - 1));
  assign w_last_word = (r_idx == IX_W'(NWORDS - 1));

  assign core_load = r_core_load;
  assign core_data = r_core_data;
  assign core_last = r_core_last;
  assign fifo_wr   = r_fifo_wr;
  assign fifo_data = r_fifo_data;
  assign done      = r_done;
  assign err       = r_err;
  assign blk_cnt   = r_blk_cnt;

  // Next-state decode for the block sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_FEED;
      S_FEED:  if (w_hs && w_key_last) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (core_done)      w_state_nxt = S_DRAIN;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      S_DRAIN: if (!fifo_full && w_last_word) w_state_nxt = S_DONE;
`ifdef TOEP_AUTO_RESTART_EN
      S_DONE:  w_state_nxt = start ? S_FEED : S_IDLE;
`else
      S_DONE:  w_state_nxt = S_IDLE;
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counters, shadow register and all registered outputs.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_key_cnt   <= '0;
      r_wait_cnt  <= '0;
      r_idx       <= '0;
      r_shadow    <= '0;
      r_core_data <= '0;
      r_core_load <= 1'b0;
      r_core_last <= 1'b0;
      r_fifo_wr   <= 1'b0;
      r_fifo_data <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_blk_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      // core_load/core_last follow a handshake by exactly one cycle.
      r_core_load <= w_hs;
      r_core_last <= w_hs & w_key_last;
      r_fifo_wr   <= 1'b0;
      r_done      <= 1'b0;
      if (w_hs) begin
        r_core_data <= in_data;
        r_key_cnt   <= r_key_cnt + 1'b1;
        if (w_key_last) r_wait_cnt <= '0;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_key_cnt <= '0;
            r_err     <= 1'b0;
          end
        end
        S_WAIT: begin
          if (core_done) begin
            r_shadow <= core_result;
            r_idx    <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
            if (w_timeout) r_err <= 1'b1;
          end
        end
        S_DRAIN: begin
          // Shifting the shadow keeps the next word at the bottom, so no wide mux.
          if (!fifo_full) begin
            r_fifo_wr   <= 1'b1;
            r_fifo_data <= r_shadow[WORD_W-1:0];
            r_shadow    <= r_shadow >> WORD_W;
            r_idx       <= r_idx + 1'b1;
            if (w_last_word) begin
              r_done    <= 1'b1;
              r_blk_cnt <= r_blk_cnt + 1'b1;
            end
          end
        end
`ifdef TOEP_AUTO_RESTART_EN
        S_DONE: begin
          if (start) r_key_cnt <= '0;
        end
`endif
        default: ;
      endcase
      // A completion pulse outside WAIT is a protocol error; it wins over a start clear.
      if (core_done && (r_state != S_WAIT)) r_err <= 1'b1;
    end
  end

endmodule
